// File: rtl/seven_seg_pkg.sv
// Shared definitions for the two-digit multiplexed seven-segment bus:
// hex glyph table, slot encoding and default driver timing.
package seven_seg_pkg;

  localparam int unsigned DEFAULT_FREQ    = 500;
  localparam int unsigned DEFAULT_TIMEOUT = 2 * (DEFAULT_FREQ + 1);

  // Segment order g,f,e,d,c,b,a (bit6..0), active-high.
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [15:0][6:0] GLYPH_TABLE = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef enum logic {
    SLOT_HI = 1'b0,
    SLOT_LO = 1'b1
  } slot_e;

endpackage

// File: rtl/seven_seg_glyph_dec.sv
// Combinational glyph-to-nibble decoder; exact match against the hex table,
// unknown glyphs yield nibble 0 with ok low.
module seven_seg_glyph_dec
  import seven_seg_pkg::*;
(
  input  logic [6:0] segment,
  output logic [3:0] nibble,
  output logic       ok
);

  always_comb begin
    nibble = '0;
    ok     = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (segment == GLYPH_TABLE[i]) begin
        nibble = 4'(i);
        ok     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_rx.sv
// Receiver for the multiplexed two-digit seven-segment bus: rebuilds the
// 14-bit pattern, decodes both digits and flags loss of strobe cadence.
module seven_seg_rx
  import seven_seg_pkg::*;
#(
  parameter int unsigned FREQ    = DEFAULT_FREQ,
  parameter int unsigned CBITS   = 11,
  parameter int unsigned TIMEOUT = 2 * (FREQ + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segment,
  input  logic        sig,
  output logic [13:0] both7seg,
  output logic [3:0]  hi_digit,
  output logic [3:0]  lo_digit,
  output logic        hi_ok,
  output logic        lo_ok,
  output logic        valid,
  output logic        lost
);

  localparam logic [CBITS-1:0] TIMEOUT_CNT = CBITS'(TIMEOUT);
  localparam logic [CBITS-1:0] CNT_ONE     = CBITS'(1);

  slot_e            slot;
  logic [CBITS-1:0] gap_cnt;
  logic [3:0]       dec_nibble;
  logic             dec_ok;

  // Only one digit arrives per strobe, so a single decoder serves both slots.
  seven_seg_glyph_dec u_glyph_dec (
    .segment (segment),
    .nibble  (dec_nibble),
    .ok      (dec_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= SLOT_HI;
      gap_cnt  <= '0;
      both7seg <= '0;
      hi_digit <= '0;
      lo_digit <= '0;
      hi_ok    <= 1'b0;
      lo_ok    <= 1'b0;
      valid    <= 1'b0;
      lost     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (sig) begin
        gap_cnt <= '0;
        if (slot == SLOT_HI) begin
          both7seg[13:7] <= segment;
          hi_digit       <= dec_nibble;
          hi_ok          <= dec_ok;
          slot           <= SLOT_LO;
        end else begin
          both7seg[6:0] <= segment;
          lo_digit      <= dec_nibble;
          lo_ok         <= dec_ok;
          valid         <= 1'b1;
          lost          <= 1'b0;
          slot          <= SLOT_HI;
        end
      end else if (gap_cnt != TIMEOUT_CNT) begin
        gap_cnt <= gap_cnt + CNT_ONE;
        // The count reaches TIMEOUT at this edge: declare loss and resync to HI.
        if (gap_cnt == TIMEOUT_CNT - CNT_ONE) begin
          lost <= 1'b1;
          slot <= SLOT_HI;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_rx.sv
// Self-checking bench for seven_seg_rx: directed vector table, hand-written
// cadence/timeout sequences and randomized traffic against a timestamp model.
module tb_seven_seg_rx;

  localparam int unsigned TO = 1002;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  segment = '0;
  logic        sig = 1'b0;
  logic [13:0] both7seg;
  logic [3:0]  hi_digit, lo_digit;
  logic        hi_ok, lo_ok, valid, lost;

  always #5 clk = ~clk;

  seven_seg_rx #(.FREQ(500), .CBITS(11), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .segment  (segment),
    .sig      (sig),
    .both7seg (both7seg),
    .hi_digit (hi_digit),
    .lo_digit (lo_digit),
    .hi_ok    (hi_ok),
    .lo_ok    (lo_ok),
    .valid    (valid),
    .lost     (lost)
  );

  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned now = 0;

  // Reference model: outputs plus "half pair pending" and time of last strobe/reset.
  logic [13:0] m_both = '0;
  logic [3:0]  m_hi = '0, m_lo = '0;
  logic        m_hiok = 1'b0, m_look = 1'b0, m_valid = 1'b0, m_lost = 1'b0;
  bit          m_pending = 1'b0;
  int unsigned last_evt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
  endtask

  function automatic void ref_decode(input logic [6:0] g, output logic [3:0] n, output logic ok);
    n = '0;
    ok = 1'b0;
    for (int i = 0; i < 16; i++)
      if (glyphs[i] == g) begin
        n = 4'(i);
        ok = 1'b1;
      end
  endfunction

  task automatic model_update(input logic r, input logic s, input logic [6:0] seg);
    logic [3:0] n;
    logic ok;
    m_valid = 1'b0;
    if (r) begin
      m_both = '0; m_hi = '0; m_lo = '0; m_hiok = 0; m_look = 0; m_lost = 0;
      m_pending = 0;
      last_evt = now;
    end else if (s) begin
      ref_decode(seg, n, ok);
      if (!m_pending) begin
        m_both = {seg, m_both[6:0]}; m_hi = n; m_hiok = ok;
        m_pending = 1;
      end else begin
        m_both = {m_both[13:7], seg}; m_lo = n; m_look = ok;
        m_valid = 1; m_lost = 0;
        m_pending = 0;
      end
      last_evt = now;
    end else if (now - last_evt >= TO) begin
      m_lost = 1;
      m_pending = 0;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [6:0] seg);
    rst = r; sig = s; segment = seg;
    @(posedge clk);
    now++;
    model_update(r, s, seg);
    #1;
    check("m_both7seg", 32'(both7seg), 32'(m_both));
    check("m_hi_digit", 32'(hi_digit), 32'(m_hi));
    check("m_lo_digit", 32'(lo_digit), 32'(m_lo));
    check("m_hi_ok",    32'(hi_ok),    32'(m_hiok));
    check("m_lo_ok",    32'(lo_ok),    32'(m_look));
    check("m_valid",    32'(valid),    32'(m_valid));
    check("m_lost",     32'(lost),     32'(m_lost));
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 7'($urandom));
  endtask

  typedef struct {
    logic        r;
    logic        s;
    logic [6:0]  seg;
    logic [13:0] both;
    logic [3:0]  hi;
    logic [3:0]  lo;
    logic        hiok;
    logic        look;
    logic        v;
    logic        lst;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int unsigned nv;
    logic [6:0] rseg;
    int unsigned gap;

    vecs[0]  = '{1'b1, 1'b0, 7'h00, 14'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 7'h06, 14'h0300, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 7'h5B, 14'h035B, 4'h1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 7'h00, 14'h035B, 4'h1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 7'h7F, 14'h3FDB, 4'h8, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 7'h01, 14'h3F81, 4'h8, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 7'h79, 14'h3C81, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 7'h71, 14'h3CF1, 4'hE, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 7'h3F, 14'h1FF1, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 7'h00, 14'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 7'h66, 14'h3300, 4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 7'h6D, 14'h336D, 4'h4, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 7'h06, 14'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 7'h3F, 14'h1F80, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 7'h00, 14'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};

    nv = 15;
    for (int unsigned i = 0; i < nv; i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].seg);
      check($sformatf("vec%0d_both", i), 32'(both7seg), 32'(vecs[i].both));
      check($sformatf("vec%0d_hi", i),   32'(hi_digit), 32'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i),   32'(lo_digit), 32'(vecs[i].lo));
      check($sformatf("vec%0d_hiok", i), 32'(hi_ok),    32'(vecs[i].hiok));
      check($sformatf("vec%0d_look", i), 32'(lo_ok),    32'(vecs[i].look));
      check($sformatf("vec%0d_valid", i), 32'(valid),   32'(vecs[i].v));
      check($sformatf("vec%0d_lost", i), 32'(lost),     32'(vecs[i].lst));
    end

    // Nominal cadence: strobes 501 cycles apart.
    step(1'b0, 1'b1, 7'h06);
    idle(500);
    check("cad_no_valid_early", 32'(valid), 32'd0);
    step(1'b0, 1'b1, 7'h5B);
    check("cad_both", 32'(both7seg), 32'h035B);
    check("cad_valid", 32'(valid), 32'd1);
    step(1'b0, 1'b0, 7'h00);
    check("cad_valid_single", 32'(valid), 32'd0);

    // Timeout after a lone HI strobe.
    step(1'b0, 1'b1, 7'h3F);
    idle(TO - 1);
    check("to_lost_before", 32'(lost), 32'd0);
    step(1'b0, 1'b0, 7'h00);
    check("to_lost_set", 32'(lost), 32'd1);
    check("to_no_valid", 32'(valid), 32'd0);
    idle(5);
    check("to_lost_sticky", 32'(lost), 32'd1);
    step(1'b0, 1'b1, 7'h77);
    check("to_hi_a", 32'(hi_digit), 32'hA);
    check("to_lost_after_hi", 32'(lost), 32'd1);
    step(1'b0, 1'b1, 7'h7C);
    check("to_lo_b", 32'(lo_digit), 32'hB);
    check("to_valid", 32'(valid), 32'd1);
    check("to_lost_cleared", 32'(lost), 32'd0);

    // Strobe landing exactly on the TIMEOUT cycle wins.
    step(1'b1, 1'b0, 7'h00);
    step(1'b0, 1'b1, 7'h06);
    idle(TO - 1);
    step(1'b0, 1'b1, 7'h5B);
    check("bnd_lost", 32'(lost), 32'd0);
    check("bnd_valid", 32'(valid), 32'd1);
    check("bnd_both", 32'(both7seg), 32'h035B);

    // Randomized traffic against the model.
    while (now < 40000) begin
      if ($urandom_range(0, 49) == 0) begin
        step(1'b1, 1'($urandom), 7'($urandom));
      end else begin
        case ($urandom_range(0, 9))
          0:       gap = $urandom_range(990, 1010);
          1, 2:    gap = $urandom_range(400, 600);
          default: gap = $urandom_range(0, 3);
        endcase
        idle(gap);
        if ($urandom_range(0, 3) != 0) rseg = glyphs[$urandom_range(0, 15)];
        else rseg = 7'($urandom);
        step(1'b0, 1'b1, rseg);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seven_seg_rx.md
# seven_seg_rx

Receiver for the two-digit multiplexed seven-segment bus. It watches the time-shared `segment` lines and the `sig` strobe produced by the digit-multiplexing driver, and rebuilds the 14-bit two-digit pattern. It decodes each digit glyph back to a hex nibble with a validity flag, and detects loss of the strobe cadence. It sits on the far side of the display interface, in loopback and self-test paths and in any block that must recover what the driver is showing.

## Interface

Parameters:
- `FREQ`, default 500: driver divider terminal count. The nominal strobe period is FREQ+1 cycles.
- `CBITS`, default 11: width of the gap counter. It must hold 2*(FREQ+1).
- `TIMEOUT`, default 2*(FREQ+1): gap length, in cycles with no strobe, that declares loss of sync.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `segment`  in  7  multiplexed glyph, bit6..0 = g,f,e,d,c,b,a, active-high.
- `sig`  in  1  strobe. High for a cycle means `segment` holds a new digit in that cycle.
- `both7seg`  out  14  reconstructed pattern: [13:7] upper digit, [6:0] lower digit.
- `hi_digit`  out  4  decoded upper nibble.
- `lo_digit`  out  4  decoded lower nibble.
- `hi_ok`  out  1  upper glyph matched the hex table.
- `lo_ok`  out  1  lower glyph matched the hex table.
- `valid`  out  1  one-cycle pulse when a complete upper+lower pair has been captured.
- `lost`  out  1  sticky loss-of-sync flag.

## Operation

- **Slot tracker:** a 1-bit state, HI or LO. It resets to HI because the first strobe after driver reset carries the upper digit.
- **Strobe handling:** every cycle with `sig`=1 at a clock edge is one strobe.
  - In HI: load `segment` into `both7seg[13:7]`, `hi_digit` and `hi_ok`, then go to LO.
  - In LO: load `segment` into `both7seg[6:0]`, `lo_digit` and `lo_ok`, pulse `valid`, clear `lost`, then go to HI.
- **Glyph decode:** exact 7-bit match against the table 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - There are no aliases.
  - A non-matching glyph gives nibble 0 with ok=0. The raw bits are still stored in `both7seg`.
- **Gap counter:**
  - Cleared on each strobe.
  - Otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT: set `lost`=1 and force the slot to HI. Any half pair already captured stays on the outputs but is not followed by `valid`.
- **Strobe on the TIMEOUT cycle:** the strobe wins. It is processed normally, the counter clears, and `lost` is not set.
- **Back-to-back strobes:** two consecutive `sig`=1 cycles are two strobes, HI then LO, and the second one pulses `valid`.
- **Reset** (at any time, including mid-pair):
  - All outputs go to 0, so `both7seg`=0, digits=0, ok=0, `valid`=0, `lost`=0.
  - Slot = HI, counter = 0.
  - Any partial pair is discarded.
- **`rst` and `sig` high in the same cycle:** reset wins and the strobe is dropped.

## Timing

- The data path has a single register stage. A strobe sampled at edge N updates its outputs, visible from N until the next update.
- `valid` is high only in the cycle following the edge that sampled the LO strobe.
- All outputs are registered. There is no combinational path from inputs to outputs.
- At nominal cadence, `valid` fires every 2*(FREQ+1) cycles, and `lost` never asserts.
- `lost` asserts at the edge where the gap count reaches TIMEOUT. With defaults this is 1002 cycles after the last strobe.

## Structure

- Package `seven_seg_pkg`:
  - The 16 glyph constants.
  - The HI/LO slot enum.
  - Default FREQ/TIMEOUT localparams, shared with the driver.
- Sub-module `seven_seg_glyph_dec`: combinational, `segment` → nibble + ok, built from the package table. Instantiate one and use it for both slots, since only one digit arrives per strobe.
- The top level holds the slot FSM, the gap counter and the output registers.

## Test plan

- **Reset then normal pair:** strobe with `segment`=7'h06, then 501 cycles later a strobe with 7'h5B.
  - Expect `both7seg`=14'h035B, `hi_digit`=1, `lo_digit`=2, both ok=1.
  - Expect a single `valid` pulse one cycle after the second strobe.
- **Invalid glyph:** strobe pair 7'h7F, 7'h01.
  - Expect `hi_digit`=8, `hi_ok`=1, `lo_digit`=0, `lo_ok`=0, `both7seg`[6:0]=7'h01.
  - `valid` still pulses.
- **Timeout:** one HI strobe (7'h3F), then no `sig` for 1002 cycles.
  - Expect `lost`=1 at that edge and no `valid`.
  - The next strobe pair 7'h77, 7'h7C gives `hi_digit`=A, `lo_digit`=B, `valid` pulses, and `lost` returns to 0.
- **Boundary:** a strobe arriving exactly on the cycle the count reaches TIMEOUT is processed, and `lost` stays 0.
- **Back-to-back strobes:** `sig` high two cycles with 7'h79 then 7'h71 gives `hi_digit`=E, `lo_digit`=F, and `valid` one cycle later.
- **Reset mid-pair:** HI strobe, then `rst` for 1 cycle, then a strobe with 7'h66.
  - The 7'h66 strobe is captured as the upper digit (`hi_digit`=4), with no `valid` yet.
  - All outputs read 0 in the cycle after reset.
